if_line_buffer: RTL and testbench

- Line buffer directly downstream of the core read master.
- Accepts 1024-bit feature-map lines tagged with First/Last markers and stores them in a FIFO.
- Presents the lines to the convolution datapath over a valid/ready handshake with row numbering.
- Drives the Halt feedback to the read master so upstream reads stall before the buffer overflows.

---
 rtl/if_line_buffer.sv | 118 +++++++++++
 tb/tb_if_line_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_line_buffer.sv
// Line FIFO between the core read master and the convolution datapath.
// Stores {first,last,line}, numbers rows per frame and raises halt before overflow.
module if_line_buffer #(
  parameter int unsigned DATA_W      = 1024,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HALT_MARGIN = 2,
  parameter int unsigned LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] line_i,
  input  logic              first_i,
  input  logic              last_i,
  output logic              halt_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_line_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic [8:0]        out_row_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              overflow_o,
  output logic              frame_done_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LvlFull   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LvlMargin = LVL_W'(HALT_MARGIN);
  localparam logic [8:0]       RowMax    = 9'd511;

  logic [DATA_W+1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [8:0]        r_row_cnt;
  logic              r_overflow;
  logic              r_frame_done;

  logic [DATA_W+1:0] w_head;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_drop;
  logic [8:0]        w_row_next;

  assign w_head      = r_mem[r_rd_ptr];
  assign out_line_o  = w_head[DATA_W-1:0];
  assign out_last_o  = w_head[DATA_W];
  assign out_first_o = w_head[DATA_W+1];
  assign out_valid_o = (r_level != '0);
  assign level_o     = r_level;
  assign overflow_o  = r_overflow;
  assign frame_done_o = r_frame_done;

  assign w_full = (r_level == LvlFull);
  assign w_pop  = out_valid_o & out_ready_i;
  // A write while full only fits if the head leaves in the same cycle.
  assign w_push = valid_i & (~w_full | w_pop);
  assign w_drop = valid_i & w_full & ~w_pop;

  // Decoded from the registered level only; the margin absorbs upstream's
  // one extra registered valid after halt.
  assign halt_o = (LvlFull - r_level) <= LvlMargin;

  assign out_row_o = out_first_o ? 9'd0 : r_row_cnt;

  always_comb begin
    w_row_next = r_row_cnt;
    if (out_last_o) begin
      w_row_next = 9'd0;
    end else if (out_row_o == RowMax) begin
      w_row_next = RowMax;
    end else begin
      w_row_next = out_row_o + 9'd1;
    end
  end

  // Storage is deliberately left unreset; head data is ignored while empty.
  always_ff @(posedge clk) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= {first_i, last_i, line_i};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_row_cnt    <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_row_cnt    <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_row_cnt <= w_row_next;
      end
      r_level      <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      r_frame_done <= w_pop & out_last_o;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_line_buffer.sv
// Scoreboard bench for if_line_buffer: a negedge reference model queues accepted
// lines with their expected row and checks them as the DUT pops them.
module tb_if_line_buffer;

  localparam int unsigned DATA_W      = 1024;
  localparam int unsigned DEPTH       = 8;
  localparam int unsigned HALT_MARGIN = 2;
  localparam int unsigned LVL_W       = $clog2(DEPTH + 1);

  logic              clk;
  logic              rstn;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] line_i;
  logic              first_i;
  logic              last_i;
  logic              halt_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_line_o;
  logic              out_first_o;
  logic              out_last_o;
  logic [8:0]        out_row_o;
  logic [LVL_W-1:0]  level_o;
  logic              overflow_o;
  logic              frame_done_o;

  if_line_buffer #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .HALT_MARGIN (HALT_MARGIN),
    .LVL_W       (LVL_W)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .line_i       (line_i),
    .first_i      (first_i),
    .last_i       (last_i),
    .halt_o       (halt_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_line_o   (out_line_o),
    .out_first_o  (out_first_o),
    .out_last_o   (out_last_o),
    .out_row_o    (out_row_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] line;
    logic              first;
    logic              last;
    logic [8:0]        row;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state, evaluated at each falling edge.
  int         m_level;
  logic       m_ovf;
  logic       m_fd;
  logic [8:0] m_row;

  always @(negedge clk) begin
    exp_t e;
    logic m_pop;
    logic m_push;
    if (!rstn) begin
      m_level = 0;
      m_ovf   = 1'b0;
      m_fd    = 1'b0;
      m_row   = 9'd0;
      sb.delete();
    end else begin
      if (frame_done_o) fd_cnt++;
      check("out_valid", 64'(out_valid_o), 64'(m_level != 0));
      check("level", 64'(level_o), 64'(m_level));
      check("halt", 64'(halt_o), 64'((DEPTH - m_level) <= HALT_MARGIN));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
      check("frame_done", 64'(frame_done_o), 64'(m_fd));
      m_pop  = (m_level != 0) && out_ready_i;
      m_push = valid_i && ((m_level < DEPTH) || m_pop);
      if (flush_i) begin
        sb.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_fd    = 1'b0;
        m_row   = 9'd0;
      end else begin
        m_fd = 1'b0;
        if (m_pop) begin
          e = sb.pop_front();
          for (int k = 0; k < DATA_W / 64; k++) begin
            check($sformatf("line[%0d]", k), out_line_o[k*64 +: 64], e.line[k*64 +: 64]);
          end
          check("out_first", 64'(out_first_o), 64'(e.first));
          check("out_last", 64'(out_last_o), 64'(e.last));
          check("out_row", 64'(out_row_o), 64'(e.row));
          m_fd = e.last;
        end
        if (m_push) begin
          e.line  = line_i;
          e.first = first_i;
          e.last  = last_i;
          e.row   = first_i ? 9'd0 : m_row;
          m_row   = last_i ? 9'd0 : ((e.row == 9'd511) ? 9'd511 : e.row + 9'd1);
          sb.push_back(e);
        end
        if (valid_i && !m_push) m_ovf = 1'b1;
        m_level = m_level + int'(m_push) - int'(m_pop);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l);
    valid_i = 1'b1;
    first_i = f;
    last_i  = l;
    for (int k = 0; k < DATA_W / 32; k++) line_i[k*32 +: 32] = $urandom;
    cyc();
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    first_i = 1'b0;
    last_i  = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    valid_i     = 1'b0;
    for (int i = 0; i < 4 * DEPTH && level_o != '0; i++) cyc();
    check("drain_level", 64'(level_o), 64'd0);
    out_ready_i = 1'b0;
  endtask

  initial begin
    int fd_base;
    rstn        = 1'b0;
    flush_i     = 1'b0;
    valid_i     = 1'b0;
    line_i      = '0;
    first_i     = 1'b0;
    last_i      = 1'b0;
    out_ready_i = 1'b0;
    #12;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_halt", 64'(halt_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_fd", 64'(frame_done_o), 64'd0);
    cyc();
    rstn = 1'b1;
    cyc();

    // 1: 4-line frame streamed with ready high.
    fd_base     = fd_cnt;
    out_ready_i = 1'b1;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    idle(4);
    check("t1_fd_pulses", 64'(fd_cnt - fd_base), 64'd1);

    // 2: six lines into a stalled consumer reach the halt threshold.
    out_ready_i = 1'b0;
    repeat (5) drive(1'b0, 1'b0);
    check("t2_halt_at5", 64'(halt_o), 64'd0);
    drive(1'b0, 1'b0);
    idle(1);
    check("t2_level", 64'(level_o), 64'd6);
    check("t2_halt", 64'(halt_o), 64'd1);
    check("t2_ovf", 64'(overflow_o), 64'd0);
    drain();

    // 3: ninth line is dropped, overflow sticks until flush.
    drive(1'b1, 1'b0);
    repeat (8) drive(1'b0, 1'b0);
    idle(1);
    check("t3_ovf", 64'(overflow_o), 64'd1);
    check("t3_level", 64'(level_o), 64'd8);
    drain();
    check("t3_ovf_sticky", 64'(overflow_o), 64'd1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("t3_ovf_flushed", 64'(overflow_o), 64'd0);

    // 4: push and pop together while full.
    drive(1'b1, 1'b0);
    repeat (7) drive(1'b0, 1'b0);
    out_ready_i = 1'b1;
    drive(1'b0, 1'b1);
    out_ready_i = 1'b0;
    idle(1);
    check("t4_level", 64'(level_o), 64'd8);
    check("t4_ovf", 64'(overflow_o), 64'd0);
    drain();

    // 5: flush mid-frame with a concurrent valid line.
    drive(1'b1, 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    flush_i = 1'b1;
    drive(1'b0, 1'b0);
    flush_i = 1'b0;
    idle(0);
    check("t5_level", 64'(level_o), 64'd0);
    check("t5_valid", 64'(out_valid_o), 64'd0);
    check("t5_halt", 64'(halt_o), 64'd0);
    out_ready_i = 1'b1;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    idle(3);

    // 6: height-1 frame then a 2-line frame.
    fd_base = fd_cnt;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    idle(4);
    check("t6_fd_pulses", 64'(fd_cnt - fd_base), 64'd2);

    // 7: long frame saturates the row counter at 511.
    drive(1'b1, 1'b0);
    repeat (514) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    idle(4);
    check("t7_empty", 64'(level_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
